ahb_sensor_bank: RTL and testbench

Parametrised AHB-Lite slave that captures up to 16 cycle-computer sensor/counter channels on per-channel sample strobes. It exposes each captured value, plus per-channel valid and overrun status, to the Cortex-M0 bus master. It replaces fixed-count switch-reading slaves: a new value is latched only when its producer strobes, not on every clock. It sits on the AHB-Lite decoder alongside the other peripherals.

---
 rtl/ahb_sensor_pkg.sv | 7 +
 rtl/sensor_channel.sv | 28 ++
 rtl/ahb_sensor_bank.sv | 102 ++++++++++
 tb/tb_ahb_sensor_bank.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_sensor_pkg.sv
// ahb_sensor_pkg: shared AHB transfer codes and register word addresses for ahb_sensor_bank.
package ahb_sensor_pkg;
    typedef enum logic [1:0] {No_Transfer = 2'b00, Busy = 2'b01, Nonseq = 2'b10, Seq = 2'b11} htrans_t;
    localparam logic [4:0] STATUS_WORD = 5'h10;
    localparam logic [4:0] IRQ_EN_WORD = 5'h11;
    localparam int MAX_CH = 16;
endpackage

// File: rtl/sensor_channel.sv
// sensor_channel: one captured value with valid/overrun flags.
// A strobe wins over a same-cycle read clear: valid stays set, overrun drops.
module sensor_channel #(
    parameter int WIDTH = 32
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             strobe,
    input  logic [WIDTH-1:0] data,
    input  logic             read_clear,
    output logic [WIDTH-1:0] value,
    output logic             valid,
    output logic             overrun
);
    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            value   <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else if (strobe) begin
            value   <= data;
            overrun <= valid && !read_clear;
            valid   <= 1'b1;
        end else if (read_clear) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
        end
endmodule

// File: rtl/ahb_sensor_bank.sv
// ahb_sensor_bank: AHB-Lite slave exposing strobed sensor channels plus valid/overrun status.
// Define AHB_SENSOR_BANK_IRQ_EN to add the IRQ_EN mask register at 0x44 and the irq output.
module ahb_sensor_bank
    import ahb_sensor_pkg::*;
#(
    parameter int NUM_CH   = 6,
    parameter int CH_WIDTH = 32
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic [31:0]                HADDR,
    input  logic [31:0]                HWDATA,
    input  logic [2:0]                 HSIZE,
    input  logic [1:0]                 HTRANS,
    input  logic                       HWRITE,
    input  logic                       HREADY,
    input  logic                       HSEL,
    output logic [31:0]                HRDATA,
    output logic                       HREADYOUT,
    input  logic [NUM_CH*CH_WIDTH-1:0] ch_data,
    input  logic [NUM_CH-1:0]          ch_strobe
`ifdef AHB_SENSOR_BANK_IRQ_EN
    ,output logic                      irq
`endif
);
    logic                access;
    logic                read_en;
    logic                write_en;
    logic [4:0]          word;
    logic [CH_WIDTH-1:0] value [NUM_CH];
    logic [NUM_CH-1:0]   valid;
    logic [NUM_CH-1:0]   overrun;
    logic [NUM_CH-1:0]   read_clear;
    logic [MAX_CH-1:0]   valid_w;
    logic [MAX_CH-1:0]   overrun_w;
    logic [31:0]         rdata;
    logic                unused;

    assign HREADYOUT = 1'b1;
    assign access    = HSEL && HREADY && HTRANS != No_Transfer;

    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            read_en  <= 1'b0;
            write_en <= 1'b0;
            word     <= '0;
        end else begin
            read_en  <= access && !HWRITE;
            write_en <= access && HWRITE;
            word     <= HADDR[6:2];
        end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign read_clear[i] = read_en && word == 5'(i);
        sensor_channel #(.WIDTH(CH_WIDTH)) u_ch (
            .HCLK      (HCLK),
            .HRESETn   (HRESETn),
            .strobe    (ch_strobe[i]),
            .data      (ch_data[i*CH_WIDTH +: CH_WIDTH]),
            .read_clear(read_clear[i]),
            .value     (value[i]),
            .valid     (valid[i]),
            .overrun   (overrun[i])
        );
    end

`ifdef AHB_SENSOR_BANK_IRQ_EN
    logic [NUM_CH-1:0] irq_en;

    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            irq_en <= '0;
            irq    <= 1'b0;
        end else begin
            if (write_en && word == IRQ_EN_WORD)
                irq_en <= HWDATA[NUM_CH-1:0];
            irq <= |(valid & irq_en);
        end

    assign unused = ^{HSIZE, HADDR[31:7], HADDR[1:0], HWDATA};
`else
    assign unused = ^{HSIZE, HADDR[31:7], HADDR[1:0], HWDATA, write_en};
`endif

    always_comb begin
        valid_w                = '0;
        overrun_w              = '0;
        valid_w[NUM_CH-1:0]    = valid;
        overrun_w[NUM_CH-1:0]  = overrun;
        rdata                  = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (word == 5'(i))
                rdata = 32'(value[i]);
        if (word == STATUS_WORD)
            rdata = {overrun_w, valid_w};
`ifdef AHB_SENSOR_BANK_IRQ_EN
        if (word == IRQ_EN_WORD)
            rdata = 32'(irq_en);
`endif
        HRDATA = read_en ? rdata : '0;
    end
endmodule

// File: tb/tb_ahb_sensor_bank.sv
// tb_ahb_sensor_bank: directed checks of capture, status, read-clear, writes and reset.
// Exercises the irq path too when AHB_SENSOR_BANK_IRQ_EN is defined.
module tb_ahb_sensor_bank;
    localparam int NUM_CH = 6;
    localparam int CH_WIDTH = 16;

    logic                       HCLK = 1'b0;
    logic                       HRESETn = 1'b0;
    logic [31:0]                HADDR = '0;
    logic [31:0]                HWDATA = '0;
    logic [2:0]                 HSIZE = 3'b010;
    logic [1:0]                 HTRANS = 2'b00;
    logic                       HWRITE = 1'b0;
    logic                       HREADY = 1'b1;
    logic                       HSEL = 1'b0;
    logic [31:0]                HRDATA;
    logic                       HREADYOUT;
    logic [NUM_CH*CH_WIDTH-1:0] ch_data = '0;
    logic [NUM_CH-1:0]          ch_strobe = '0;
`ifdef AHB_SENSOR_BANK_IRQ_EN
    logic                       irq;
`endif

    int vectors = 0;
    int miscompares = 0;

    ahb_sensor_bank #(.NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWDATA(HWDATA), .HSIZE(HSIZE),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HREADY(HREADY), .HSEL(HSEL), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .ch_data(ch_data), .ch_strobe(ch_strobe)
`ifdef AHB_SENSOR_BANK_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 HCLK = ~HCLK;

    // Read with an optional channel strobe during the data phase (sch < 0 means none).
    task automatic ahb_read(input logic [31:0] addr, input int sch, input logic [15:0] sval,
                            output logic [31:0] data);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0;
        if (sch >= 0) begin
            ch_data[sch*CH_WIDTH +: CH_WIDTH] = sval;
            ch_strobe[sch] = 1'b1;
        end
        #1 data = HRDATA;
        @(posedge HCLK);
        #1 ch_strobe = '0;
    endtask

    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0; HWDATA = wdata;
        @(posedge HCLK);
        #1 HWDATA = '0;
    endtask

    task automatic strobe(input int ch, input logic [15:0] val);
        @(negedge HCLK);
        ch_data[ch*CH_WIDTH +: CH_WIDTH] = val;
        ch_strobe[ch] = 1'b1;
        @(negedge HCLK);
        ch_strobe = '0;
    endtask

    task automatic expect_read(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        ahb_read(addr, -1, '0, d);
        vectors++;
        if (d !== exp) begin
            miscompares++;
            $display("FAIL %s addr=%h got=%h want=%h", name, addr, d, exp);
        end
    endtask

    task automatic test_reset;
        HRESETn = 1'b0;
        repeat (2) @(negedge HCLK);
        vectors++;
        if (HRDATA !== 32'h0 || HREADYOUT !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h/%b want=0/1", HRDATA, HREADYOUT);
        end
        HRESETn = 1'b1;
        for (int a = 0; a <= 'h44; a += 4) begin
            expect_read("reset_read", 32'(a), 32'h0);
            vectors++;
            if (HREADYOUT !== 1'b1) begin
                miscompares++;
                $display("FAIL hreadyout got=%b want=1", HREADYOUT);
            end
        end
    endtask

    task automatic test_capture;
        strobe(2, 16'hBEEF);
        expect_read("status_ch2", 32'h40, 32'h0000_0004);
        expect_read("data_ch2", 32'h08, 32'h0000_BEEF);
        expect_read("status_cleared", 32'h40, 32'h0);
        strobe(5, 16'hFFFF);
        expect_read("zero_ext_ch5", 32'h14, 32'h0000_FFFF);
    endtask

    task automatic test_overrun;
        strobe(0, 16'h0011);
        strobe(0, 16'h0022);
        expect_read("status_overrun", 32'h40, 32'h0001_0001);
        expect_read("data_ch0", 32'h00, 32'h0000_0022);
        expect_read("overrun_cleared", 32'h40, 32'h0);
    endtask

    task automatic test_same_cycle;
        logic [31:0] d;
        strobe(3, 16'h0005);
        ahb_read(32'h0C, 3, 16'h0009, d);
        vectors++;
        if (d !== 32'h5) begin
            miscompares++;
            $display("FAIL same_cycle_old got=%h want=%h", d, 32'h5);
        end
        expect_read("same_cycle_status", 32'h40, 32'h0000_0008);
        expect_read("same_cycle_new", 32'h0C, 32'h0000_0009);
        expect_read("same_cycle_cleared", 32'h40, 32'h0);
    endtask

    task automatic test_write_ignored;
        strobe(1, 16'h1234);
        ahb_write(32'h04, 32'h0000_FFFF);
        ahb_write(32'h40, 32'hFFFF_FFFF);
        expect_read("write_status", 32'h40, 32'h0000_0002);
        expect_read("write_ch1", 32'h04, 32'h0000_1234);
        ahb_write(32'h44, 32'h0000_0015);
`ifdef AHB_SENSOR_BANK_IRQ_EN
        expect_read("irq_en_rw", 32'h44, 32'h0000_0015);
        ahb_write(32'h44, 32'h0);
`else
        expect_read("irq_en_absent", 32'h44, 32'h0);
`endif
        expect_read("unmapped", 32'h48, 32'h0);
    endtask

`ifdef AHB_SENSOR_BANK_IRQ_EN
    task automatic check_irq(input string name, input logic exp);
        vectors++;
        if (irq !== exp) begin
            miscompares++;
            $display("FAIL %s irq=%b want=%b", name, irq, exp);
        end
    endtask

    task automatic test_irq;
        ahb_write(32'h44, 32'h2);
        expect_read("irq_mask", 32'h44, 32'h2);
        strobe(1, 16'h00AA);
        check_irq("irq_same_as_valid", 1'b0);
        @(negedge HCLK);
        check_irq("irq_rise", 1'b1);
        expect_read("irq_read_ch1", 32'h04, 32'h0000_00AA);
        @(negedge HCLK);
        check_irq("irq_hold", 1'b1);
        @(negedge HCLK);
        check_irq("irq_fall", 1'b0);
        strobe(0, 16'h0001);
        @(negedge HCLK);
        check_irq("irq_masked", 1'b0);
        expect_read("irq_clean_ch0", 32'h00, 32'h1);
    endtask
`endif

    task automatic test_reset_mid_transfer;
        strobe(4, 16'hCAFE);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h10;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00;
        #1;
        vectors++;
        if (HRDATA !== 32'h0000_CAFE) begin
            miscompares++;
            $display("FAIL pre_reset_read got=%h want=%h", HRDATA, 32'h0000_CAFE);
        end
        HRESETn = 1'b0;
        #1;
        vectors++;
        if (HRDATA !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_inflight got=%h want=0", HRDATA);
        end
        @(negedge HCLK);
        HRESETn = 1'b1;
        expect_read("reset_store", 32'h10, 32'h0);
        expect_read("reset_status", 32'h40, 32'h0);
    endtask

    initial begin
        test_reset;
        test_capture;
        test_overrun;
        test_same_cycle;
        test_write_ignored;
`ifdef AHB_SENSOR_BANK_IRQ_EN
        test_irq;
`endif
        test_reset_mid_transfer;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
